ac_mode_sequencer: RTL and testbench

//   Produces the 2-bit mode_selection that drives the AC mode multiplexer.

---
 rtl/ac_mode_sequencer_if.sv | 28 ++
 rtl/ac_mode_sequencer.sv | 117 +++++++++++
 tb/tb_ac_mode_sequencer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/ac_mode_sequencer_if.sv
// Command handshake and mode outputs between the controller and the AC mode sequencer.
// The master drives commands; the slave (sequencer) drives ready, mode and status.
interface ac_mode_sequencer_if;
  logic       cmd_valid;
  logic [1:0] cmd_mode;
  logic       cmd_ready;
  logic [1:0] mode_selection;
  logic       mode_change;
  logic       busy;

  modport master (
    output cmd_valid,
    output cmd_mode,
    input  cmd_ready,
    input  mode_selection,
    input  mode_change,
    input  busy
  );

  modport slave (
    input  cmd_valid,
    input  cmd_mode,
    output cmd_ready,
    output mode_selection,
    output mode_change,
    output busy
  );
endinterface

// File: rtl/ac_mode_sequencer.sv
// AC mode selector: debounced panel button plus valid/ready command port, with an
// OFF lockout inserted between direct COOL<->HEAT changes. Mode updates land one edge after acceptance.
module ac_mode_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int LOCKOUT_CYCLES  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_next,
  ac_mode_sequencer_if.slave bus
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  localparam logic [1:0] M_OFF  = 2'b00;
  localparam logic [1:0] M_COOL = 2'b10;
  localparam logic [1:0] M_HEAT = 2'b11;

  typedef enum logic {S_IDLE, S_LOCKOUT} state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_mode, w_mode_nxt;
  logic [1:0]    r_target, w_target_nxt;
  logic          r_change, w_change_nxt;
  logic [LW-1:0] r_lock_cnt, w_lock_cnt_nxt;
  logic [DW-1:0] r_db_cnt, w_db_cnt_nxt;
  logic          r_armed, w_armed_nxt;

  logic          w_press;
  logic          w_cmd_acc;
  logic [1:0]    w_req_mode;
  logic          w_cross;

  assign bus.cmd_ready      = (r_state == S_IDLE);
  assign bus.busy           = (r_state == S_LOCKOUT);
  assign bus.mode_selection = r_mode;
  assign bus.mode_change    = r_change;

  assign w_cmd_acc  = bus.cmd_valid && (r_state == S_IDLE);
  // A command always wins; a press arriving on the same edge is simply lost.
  assign w_req_mode = w_cmd_acc ? bus.cmd_mode : (r_mode + 2'd1);
  assign w_cross    = ((r_mode == M_COOL) && (w_req_mode == M_HEAT)) ||
                      ((r_mode == M_HEAT) && (w_req_mode == M_COOL));

  always_comb begin
    w_db_cnt_nxt = r_db_cnt;
    w_armed_nxt  = r_armed;
    w_press      = 1'b0;
    if (!btn_next) begin
      w_db_cnt_nxt = '0;
      w_armed_nxt  = 1'b1;
    end else begin
      if (r_db_cnt != DW'(DEBOUNCE_CYCLES)) begin
        w_db_cnt_nxt = r_db_cnt + 1'b1;
      end
      // Fires on the sample that completes the run; disarmed until the button is released.
      if (r_armed && (r_db_cnt == DW'(DEBOUNCE_CYCLES - 1))) begin
        w_press     = 1'b1;
        w_armed_nxt = 1'b0;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_mode_nxt     = r_mode;
    w_target_nxt   = r_target;
    w_lock_cnt_nxt = r_lock_cnt;
    w_change_nxt   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((w_cmd_acc || w_press) && (w_req_mode != r_mode)) begin
          if (w_cross) begin
            w_mode_nxt     = M_OFF;
            w_target_nxt   = w_req_mode;
            w_lock_cnt_nxt = LW'(LOCKOUT_CYCLES - 1);
            w_state_nxt    = S_LOCKOUT;
          end else begin
            w_mode_nxt   = w_req_mode;
            w_change_nxt = 1'b1;
          end
        end
      end
      default: begin
        if (r_lock_cnt == '0) begin
          w_mode_nxt   = r_target;
          w_change_nxt = 1'b1;
          w_state_nxt  = S_IDLE;
        end else begin
          w_lock_cnt_nxt = r_lock_cnt - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_mode     <= M_OFF;
      r_target   <= M_OFF;
      r_change   <= 1'b0;
      r_lock_cnt <= '0;
      r_db_cnt   <= '0;
      r_armed    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_mode     <= w_mode_nxt;
      r_target   <= w_target_nxt;
      r_change   <= w_change_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      r_db_cnt   <= w_db_cnt_nxt;
      r_armed    <= w_armed_nxt;
    end
  end

endmodule

// File: tb/tb_ac_mode_sequencer.sv
// Directed bench for ac_mode_sequencer: reset, commands, debounce, wrap, lockout, priority, reset mid-lockout.
module tb_ac_mode_sequencer;

  logic clk;
  logic rst;
  logic btn_next;
  int   n_checks;
  int   n_errors;

  ac_mode_sequencer_if bus ();

  ac_mode_sequencer #(
    .DEBOUNCE_CYCLES (4),
    .LOCKOUT_CYCLES  (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_next (btn_next),
    .bus      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] m);
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = m;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  initial begin
    int n;
    int pulses;
    int bad;

    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    btn_next      = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_mode  = 2'b00;

    // 1: reset
    tick();
    tick();
    rst = 1'b0;
    check("rst_mode",   32'(bus.mode_selection), 0);
    check("rst_change", 32'(bus.mode_change),    0);
    check("rst_busy",   32'(bus.busy),           0);
    check("rst_ready",  32'(bus.cmd_ready),      1);
    tick();

    // 2: command OFF->FAN, then a same-mode command
    send_cmd(2'b01);
    check("cmd_fan_mode",   32'(bus.mode_selection), 1);
    check("cmd_fan_change", 32'(bus.mode_change),    1);
    tick();
    check("cmd_fan_pulse1", 32'(bus.mode_change), 0);
    send_cmd(2'b01);
    check("cmd_same_mode",   32'(bus.mode_selection), 1);
    check("cmd_same_change", 32'(bus.mode_change),    0);
    send_cmd(2'b00);
    check("cmd_off_mode", 32'(bus.mode_selection), 0);
    tick();

    // 3: short glitch, long hold, wrap
    btn_next = 1'b1;
    repeat (3) tick();
    btn_next = 1'b0;
    tick();
    check("btn_short_mode", 32'(bus.mode_selection), 0);
    btn_next = 1'b1;
    pulses   = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.mode_change) pulses++;
    end
    check("btn_hold_pulses", 32'(pulses), 1);
    check("btn_hold_mode",   32'(bus.mode_selection), 1);
    btn_next = 1'b0;
    tick();
    send_cmd(2'b11);
    check("cmd_heat_direct", 32'(bus.mode_selection), 3);
    btn_next = 1'b1;
    repeat (3) tick();
    check("btn_wrap_pre", 32'(bus.mode_selection), 3);
    tick();
    check("btn_wrap_mode",   32'(bus.mode_selection), 0);
    check("btn_wrap_change", 32'(bus.mode_change),    1);
    btn_next = 1'b0;
    tick();

    // 4: COOL->HEAT lockout with a command held pending
    send_cmd(2'b10);
    check("cool_direct", 32'(bus.mode_selection), 2);
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = 2'b11;
    tick();
    bus.cmd_mode = 2'b01;
    check("lock_enter_change", 32'(bus.mode_change), 0);
    n   = 0;
    bad = 0;
    while (bus.busy && n < 40) begin
      if (bus.mode_selection != 2'b00 || bus.cmd_ready || bus.mode_change) bad++;
      n++;
      tick();
    end
    check("lock_cycles",    32'(n),   16);
    check("lock_bad_cycles", 32'(bad), 0);
    check("lock_exit_mode",   32'(bus.mode_selection), 3);
    check("lock_exit_change", 32'(bus.mode_change),    1);
    check("lock_exit_ready",  32'(bus.cmd_ready),      1);
    tick();
    bus.cmd_valid = 1'b0;
    check("pending_cmd_mode",   32'(bus.mode_selection), 1);
    check("pending_cmd_change", 32'(bus.mode_change),    1);
    tick();

    // 5: command and completed press on the same edge at FAN
    btn_next = 1'b1;
    repeat (3) tick();
    check("prio_pre_mode", 32'(bus.mode_selection), 1);
    send_cmd(2'b10);
    check("prio_mode", 32'(bus.mode_selection), 2);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.mode_change) pulses++;
    end
    check("prio_no_extra_pulse", 32'(pulses), 0);
    check("prio_hold_mode",      32'(bus.mode_selection), 2);
    btn_next = 1'b0;
    tick();

    // 6: reset five cycles into a HEAT->COOL lockout
    send_cmd(2'b00);
    send_cmd(2'b11);
    check("heat_mode", 32'(bus.mode_selection), 3);
    send_cmd(2'b10);
    check("lock2_busy", 32'(bus.busy), 1);
    repeat (4) tick();
    check("lock2_still_busy", 32'(bus.busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_mid_mode",  32'(bus.mode_selection), 0);
    check("rst_mid_busy",  32'(bus.busy),           0);
    check("rst_mid_ready", 32'(bus.cmd_ready),      1);
    pulses = 0;
    bad    = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.mode_change) pulses++;
      if (bus.mode_selection != 2'b00) bad++;
    end
    check("rst_mid_no_pulse", 32'(pulses), 0);
    check("rst_mid_no_cool",  32'(bad),    0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
